// File: rtl/div_16_if.sv
// div_16_if: start/done handshake and operand/result bus between the
// control unit (master) and the divider (slave).
interface div_16_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             busy;
    logic             done;
    logic             dbz;

    modport master (
        output start, x, y,
        input  q, r, busy, done, dbz
    );

    modport slave (
        input  start, x, y,
        output q, r, busy, done, dbz
    );
endinterface

// File: rtl/div_16.sv
// div_16: sequential restoring divider, one quotient bit per clock.
// Optional macro DIV16_SIGNED_EN: two's complement operands, magnitudes are
// divided and a one-cycle FIX state applies the signs afterwards.
//
// state | meaning
// IDLE  | waiting for start, results held
// CALC  | one trial subtraction per clock, WIDTH iterations
// FIX   | (signed build only) apply quotient/remainder signs
// DONE  | one-cycle done pulse, start accepted back-to-back
module div_16 #(
    parameter int WIDTH = 16
) (
    input  logic     clk,
    input  logic     rst,
    div_16_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] r_q;
    logic             busy_q;
    logic             done_q;
    logic             dbz_q;
`ifdef DIV16_SIGNED_EN
    logic             qneg_q;
    logic             rneg_q;
`endif

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] quo_d;
    logic [WIDTH-1:0] mag_x;
    logic [WIDTH-1:0] mag_y;

    // Trial subtraction for the current iteration; the partial remainder is
    // at most 2*y-1, so bit WIDTH of the difference is a reliable sign bit.
    always_comb begin
        rem_sh = {rem_q, dvd_q[WIDTH-1]};
        diff   = rem_sh - {1'b0, dvs_q};
        if (!diff[WIDTH]) begin
            rem_d = diff[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_d = rem_sh[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
    end

    // Operand magnitudes fed into the iteration registers at start.
    always_comb begin
`ifdef DIV16_SIGNED_EN
        mag_x = bus.x[WIDTH-1] ? -bus.x : bus.x;
        mag_y = bus.y[WIDTH-1] ? -bus.y : bus.y;
`else
        mag_x = bus.x;
        mag_y = bus.y;
`endif
    end

    // Control FSM with registered handshake outputs and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
`ifdef DIV16_SIGNED_EN
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        dvd_q <= mag_x;
                        dvs_q <= mag_y;
                        rem_q <= '0;
                        quo_q <= '0;
                        cnt_q <= '0;
`ifdef DIV16_SIGNED_EN
                        qneg_q <= bus.x[WIDTH-1] ^ bus.y[WIDTH-1];
                        rneg_q <= bus.x[WIDTH-1];
`endif
                        if (bus.y != '0) begin
                            busy_q  <= 1'b1;
                            state_q <= CALC;
                        end else begin
                            // Divide by zero resolves immediately, busy never rises.
                            q_q     <= '1;
                            r_q     <= bus.x;
                            dbz_q   <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                CALC: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    dvd_q <= {dvd_q[WIDTH-2:0], 1'b0};
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) begin
`ifdef DIV16_SIGNED_EN
                        state_q <= FIX;
`else
                        q_q     <= quo_d;
                        r_q     <= rem_d;
                        dbz_q   <= 1'b0;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= DONE;
`endif
                    end
                end
`ifdef DIV16_SIGNED_EN
                FIX: begin
                    q_q     <= qneg_q ? -quo_q : quo_q;
                    r_q     <= rneg_q ? -rem_q : rem_q;
                    dbz_q   <= 1'b0;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= DONE;
                end
`endif
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.q    = q_q;
    assign bus.r    = r_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.dbz  = dbz_q;
endmodule

// File: doc/div_16.md
Name: div_16

Overview:
- Sequential 16-bit unsigned restoring divider for the CPU datapath.
- Inverse operation to the ripple adder: one trial subtraction per clock, one quotient bit per cycle.
- Start/done handshake with the control unit; results held until the next accepted start.

Parameters:
- WIDTH, 16, operand/result width in bits; all tests use 16.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a division; sampled only when busy=0.
- x  input  WIDTH  dividend.
- y  input  WIDTH  divisor.
- q  output  WIDTH  quotient, registered.
- r  output  WIDTH  remainder, registered.
- busy  output  1  high while a division is in progress.
- done  output  1  one-cycle pulse when q/r become valid.
- dbz  output  1  divide-by-zero flag, valid with done, held with results.

Behaviour:
- Reset (async, any time, including mid-operation):
  - state=IDLE.
  - q=0, r=0, busy=0, done=0, dbz=0.
  - Internal counter and operand registers cleared.
  - In-flight division is discarded; no done pulse follows.
- States: IDLE, CALC, DONE.
- IDLE or DONE, start=1 at edge N:
  - Latch x and y; clear the partial remainder; counter=0.
  - If y!=0: busy=1, go to CALC.
  - If y==0: go to DONE at edge N with q=all ones, r=x, dbz=1, done=1. Busy never rises.
- CALC, each edge, counter 0..WIDTH-1:
  - Shift {rem,quo} left one bit, shifting in the dividend MSB.
  - Compute rem-y in WIDTH+1 bits.
  - If the result is non-negative (bit WIDTH=0): rem=difference and the new quo LSB=1. Otherwise keep rem and set quo LSB=0.
- After the WIDTH-th iteration (edge N+WIDTH):
  - Load q=quo, r=rem, dbz=0, done=1, busy=0; go to DONE.
- Latency: done is high in the cycle after edge N+WIDTH, i.e. WIDTH cycles after the start edge.
- DONE lasts exactly one cycle:
  - Next edge goes to IDLE, done=0.
  - A start seen in the DONE cycle is accepted (back-to-back operation), and done still drops.
- start while busy=1: ignored; operands are not resampled.
- q, r and dbz hold their values until the next accepted start produces new results. They do not change during CALC.
- Invariant: x = q*y + r with r < y for all y!=0.

Optional Feature:
- Macro: DIV16_SIGNED_EN.
- Defined:
  - Operands are two's complement.
  - CALC runs on the magnitudes.
  - An extra FIX state (one cycle) negates q if sign(x)^sign(y), and negates r if sign(x).
  - Latency is WIDTH+1.
  - Quotient truncates toward zero; the remainder takes the sign of the dividend.
  - 0x8000/0xFFFF gives q=0x8000, r=0, dbz=0 (overflow wraps).
  - y==0 gives q=0xFFFF, r=x, dbz=1.
- Undefined:
  - Unsigned-only operation, no FIX state, latency WIDTH.

Test Plan:
- x=100, y=7, start pulse -> done exactly 16 cycles later; q=14, r=2, dbz=0; busy high for 16 cycles.
- x=0xFFFF, y=1 -> q=0xFFFF, r=0. Then x=0x1234, y=0xFFFF -> q=0, r=0x1234.
- x=0x00AB, y=0 -> done the cycle after the start edge; q=0xFFFF, r=0x00AB, dbz=1; busy never asserts.
- Start x=50,y=5. Pulse start with x=9,y=2 during cycle 5 of CALC -> ignored; result q=10, r=0. Start x=9,y=2 in the DONE cycle -> q=4, r=1 after 16 more cycles.
- Assert rst during cycle 8 of CALC -> all outputs 0 immediately (asynchronously), no done pulse, IDLE. A subsequent start x=1000, y=33 -> q=30, r=10.
- With DIV16_SIGNED_EN:
  - x=0xFFF9 (-7), y=2 -> q=0xFFFD (-3), r=0xFFFF (-1), latency 17.
  - x=0x8000, y=0xFFFF -> q=0x8000, r=0.
